diagonal_walker: RTL
====================

# diagonal_walker

Parametrised diagonal-walk state machine with a built-in safety monitor. Two W-bit coordinates, X and Y, step under an enable according to a fixed walk/fold/swap rule. The block continuously evaluates the invariant `prop = !(X < Y)`. It latches the first violation together with the step index at which it occurred. It is the generalised, monitored successor of the fixed 4-bit diagonal benchmark, and is used as a model-checking and simulation target in the formal suite.

## Interface
- `W`, 4: coordinate width in bits (≥2).
- `KMAX`, 2^W−1: swap threshold and fold ceiling; must satisfy 1 ≤ KMAX ≤ 2^W−1.
- `CNT_W`, 8: width of the step counter and of `fail_step`.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: reset; synchronous, active-high.
- `en`, in, 1: step enable; a step occurs on every edge where `en`=1.
- `fold`, in, 1: fold request; only acts when `en`=1 and X>Y.
- `x`, out, W: current X.
- `y`, out, W: current Y.
- `prop`, out, 1: combinational invariant, `!(x < y)`.
- `viol`, out, 1: sticky violation flag.
- `steps`, out, CNT_W: number of steps taken; saturating.
- `fail_step`, out, CNT_W: value of `steps` when `viol` was set.

## Operation
- Reset values: x=1, y=0, prop=1, viol=0, steps=0, fail_step=0, FSM=RUN.
- Next-state rule. Apply the first matching branch, and only when `en`=1:
  1. `fold` and X>Y: X ← min((KMAX>>1)+(X>>1), KMAX), computed in W+1 bits; Y holds.
  2. X<Y: X holds; Y ← Y+1 mod 2^W.
  3. X==Y: X ← X+1 mod 2^W; Y ← Y+1 mod 2^W.
  4. X>Y and X≠KMAX: X ← X+1; Y ← Y+1 (both mod 2^W).
  5. X>Y and X==KMAX: swap, so X ← Y and Y ← X.
- When `en`=0, X, Y and `steps` hold, and `fold` is ignored.
- `steps` increments by 1 on each step and saturates at 2^CNT_W−1.
- Monitor FSM, states RUN and TRIPPED:
  - RUN → TRIPPED on an edge where `prop`=0. That edge also sets `viol`=1 and captures `fail_step` ← `steps`.
  - TRIPPED persists until reset. `fail_step` is frozen in TRIPPED, and later violations are ignored.
  - The walk continues in both states; the monitor never stalls the datapath.
- Comparisons are unsigned.

## Timing
- Step latency is 1 cycle: a step with `en`=1 at edge n is visible on x/y after edge n.
- `prop` is combinational from the registered X/Y, so it is valid in the same cycle as x/y.
- `viol` and `fail_step` update one edge after `prop` first goes low. `fail_step` therefore equals the `steps` value of the step that produced the violating state.
- `steps` saturation has no effect on the walk.
- Reset asserted mid-walk or in TRIPPED takes priority over `en` and `fold`, and forces all reset values at the next edge.
- Reset together with `prop`=0 in the same cycle does not set `viol`.

## Structure
- Package `diagonal_pkg`:
  - monitor state enum (RUN, TRIPPED);
  - init constants X0=1 and Y0=0, expressed as functions of W.
- Sub-module `diag_step` is purely combinational.
  - Inputs: X, Y, fold.
  - Output: next X and next Y.
  - Parameters: W, KMAX.
  - It is reused by formal harnesses that need the transition relation in isolation.
- The top level contains the X/Y registers, the step counter and the monitor FSM.

## Test plan
All scenarios use W=4, KMAX=15, CNT_W=8.
- Reset, then idle with `en`=0 for 5 cycles → x=1, y=0, prop=1, viol=0, steps=0 throughout.
- `en`=1 for 3 cycles from reset → (2,1), (3,2), (4,3); steps=3; prop stays 1.
- `en`=1 for 15 cycles from reset:
  - step 14 gives (15,14);
  - step 15 swaps to (14,15) with prop=0;
  - on the next edge viol=1 and fail_step=15;
  - with `en` still 1, the following step gives (14,0).
- `fold` tests:
  - at (4,3) with fold=1 and en=1 → (9,3) and steps+1;
  - at (15,0) with fold=1 → (14,0);
  - at (3,3) with fold=1 → (4,4), since the fold is ignored when X==Y.
- Hold behaviour: en=0 with fold=1 at (5,4) for 4 cycles → state, steps and viol all unchanged.
- Reset while in TRIPPED with en=1 → next edge x=1, y=0, viol=0, fail_step=0, steps=0, FSM=RUN.

Source files
------------

// File: rtl/diagonal_pkg.sv
// Shared types and constants for the diagonal walker and its formal harnesses.
package diagonal_pkg;

    typedef enum logic {
        StRun,
        StTripped
    } mon_state_e;

    // Reset coordinates, truncated to a w-bit coordinate.
    function automatic int unsigned init_x(input int unsigned w);
        return 32'd1 & ((32'd1 << w) - 32'd1);
    endfunction

    function automatic int unsigned init_y(input int unsigned w);
        return 32'd0 & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/diag_step.sv
// Combinational transition relation of the diagonal walk: (x, y, fold) -> (x', y').
module diag_step #(
    parameter int unsigned W    = 4,
    parameter int unsigned KMAX = (1 << W) - 1
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    input  logic         fold_i,
    output logic [W-1:0] x_o,
    output logic [W-1:0] y_o
);

    localparam logic [W:0]   KmaxExt  = (W + 1)'(KMAX);
    localparam logic [W:0]   KmaxHalf = KmaxExt >> 1;
    localparam logic [W-1:0] KmaxW    = W'(KMAX);

    logic [W:0]   fold_sum;
    logic [W-1:0] fold_x;

    always_comb begin
        // One extra bit so the fold sum cannot wrap before the clamp.
        fold_sum = KmaxHalf + {2'b00, x_i[W-1:1]};
        fold_x   = (fold_sum > KmaxExt) ? KmaxW : fold_sum[W-1:0];

        x_o = x_i;
        y_o = y_i;
        if (fold_i && (x_i > y_i)) begin
            x_o = fold_x;
        end else if (x_i < y_i) begin
            y_o = y_i + W'(1);
        end else if (x_i == y_i) begin
            x_o = x_i + W'(1);
            y_o = y_i + W'(1);
        end else if (x_i != KmaxW) begin
            x_o = x_i + W'(1);
            y_o = y_i + W'(1);
        end else begin
            x_o = y_i;
            y_o = x_i;
        end
    end

endmodule

// File: rtl/diagonal_walker.sv
// Diagonal-walk datapath with a sticky monitor latching the first violation of !(x < y).
module diagonal_walker
    import diagonal_pkg::*;
#(
    parameter int unsigned W     = 4,
    parameter int unsigned KMAX  = (1 << W) - 1,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             fold,
    output logic [W-1:0]     x,
    output logic [W-1:0]     y,
    output logic             prop,
    output logic             viol,
    output logic [CNT_W-1:0] steps,
    output logic [CNT_W-1:0] fail_step
);

    localparam logic [W-1:0]     X0       = W'(init_x(W));
    localparam logic [W-1:0]     Y0       = W'(init_y(W));
    localparam logic [CNT_W-1:0] StepsMax = '1;

    logic [W-1:0]     x_q, y_q, x_d, y_d;
    logic [W-1:0]     x_step, y_step;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic [CNT_W-1:0] fail_step_q, fail_step_d;
    logic             viol_q, viol_d;
    mon_state_e       state_q, state_d;

    diag_step #(
        .W    (W),
        .KMAX (KMAX)
    ) u_diag_step (
        .x_i    (x_q),
        .y_i    (y_q),
        .fold_i (fold),
        .x_o    (x_step),
        .y_o    (y_step)
    );

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        steps_d = steps_q;
        if (en) begin
            x_d = x_step;
            y_d = y_step;
            if (steps_q != StepsMax) begin
                steps_d = steps_q + CNT_W'(1);
            end
        end
    end

    // Monitor only observes; it never gates the walk.
    always_comb begin
        state_d     = state_q;
        viol_d      = viol_q;
        fail_step_d = fail_step_q;
        case (state_q)
            StRun: begin
                if (!prop) begin
                    state_d     = StTripped;
                    viol_d      = 1'b1;
                    fail_step_d = steps_q;
                end
            end
            StTripped: begin
                state_d = StTripped;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q         <= X0;
            y_q         <= Y0;
            steps_q     <= '0;
            fail_step_q <= '0;
            viol_q      <= 1'b0;
            state_q     <= StRun;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            steps_q     <= steps_d;
            fail_step_q <= fail_step_d;
            viol_q      <= viol_d;
            state_q     <= state_d;
        end
    end

    assign prop      = !(x_q < y_q);
    assign x         = x_q;
    assign y         = y_q;
    assign viol      = viol_q;
    assign steps     = steps_q;
    assign fail_step = fail_step_q;

endmodule
